// File: rtl/mem_access_stage.sv
// Purpose : pipeline memory stage; runs a load/store on the data-memory port, hands results to Writeback.
// Latency : 1 cycle for non-memory or illegal ops; 2+ cycles for memory ops (ack cycle + 1).
// Backpressure: in_ready low while a memory access is in flight or a result waits on out_ready.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-low reset
//   in_valid/in_ready - op handshake from Execute (mem_read, mem_write, alu_result, write_data)
//   out_valid/out_ready - result handshake to Writeback (result, err)
//   mem_req/mem_we/mem_addr/mem_wdata - data-memory request, held stable while mem_req=1
//   mem_ack/mem_rdata - one-cycle completion pulse with read data
//
// Optional build macro: MEMACC_TIMEOUT_EN -- abort an access after TIMEOUT cycles without mem_ack,
// completing it with err=1 and result=0. Without the macro the stage waits indefinitely.
module mem_access_stage #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] write_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic is_mem;
    logic illegal;
    logic to_hit;

    // Exactly one of read/write is a memory op; both set is an illegal op that never reaches memory.
    assign is_mem  = mem_read ^ mem_write;
    assign illegal = mem_read & mem_write;
    assign accept  = in_valid & in_ready;

`ifdef MEMACC_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] to_cnt;

    // Counts ACCESS cycles without an ack; cleared whenever a new memory op is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (accept && is_mem) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !mem_ack) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // An ack arriving in the expiry cycle takes priority over the abort.
    assign to_hit = (state == ACCESS) && !mem_ack && (to_cnt == CW'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;

    // TIMEOUT only matters when the abort counter is built in.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                // A new op accepted in DONE is handled exactly as from IDLE, so
                // back-to-back ops flow without a bubble.
                if (accept) begin
                    state_nxt = is_mem ? ACCESS : DONE;
                end else if (state == DONE && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ack || to_hit) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state == DONE);
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    end

    // ------------------------------------------------------------------
    // Registered datapath: memory request and result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            result    <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            if (is_mem) begin
                mem_req   <= 1'b1;
                mem_we    <= mem_write;
                mem_addr  <= alu_result;
                mem_wdata <= write_data;
            end else begin
                // Non-memory and illegal ops both pass alu_result through;
                // err marks the illegal case.
                result <= alu_result;
                err    <= illegal;
            end
        end else if (state == ACCESS) begin
            if (mem_ack) begin
                mem_req <= 1'b0;
                err     <= 1'b0;
                // A store reports the data it wrote, taken from the held
                // request rather than the live Execute bus.
                result  <= mem_we ? mem_wdata : mem_rdata;
            end else if (to_hit) begin
                mem_req <= 1'b0;
                err     <= 1'b1;
                result  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose : directed self-checking bench for mem_access_stage.
// Latency : n/a (bench).
// Backpressure: bench drives out_ready directly to exercise holding and back-to-back flow.
module tb_mem_access_stage;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] write_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             err;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_result (alu_result),
        .write_data (write_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic rd, input logic wr,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        in_valid   = v;
        mem_read   = rd;
        mem_write  = wr;
        alu_result = a;
        write_data = d;
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        step();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_mem_req",   mem_req,   0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_result",    result,    0);
        chk("rst_err",       err,       0);
        reset = 1'b1;
        step();

        // Non-memory op: latency 1, no memory request
        out_ready = 1'b1;
        drive_op(1'b1, 1'b0, 1'b0, 8'h3C, 8'h00);
        step();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("nm_out_valid", out_valid, 1);
        chk("nm_result",    result,    8'h3C);
        chk("nm_err",       err,       0);
        chk("nm_mem_req",   mem_req,   0);
        step();
        chk("nm_idle_valid", out_valid, 0);

        // Load with ack in the third ACCESS cycle
        drive_op(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("ld_req_c1",   mem_req,  1);
        chk("ld_addr",     mem_addr, 8'h10);
        chk("ld_we",       mem_we,   0);
        chk("ld_rdy_c1",   in_ready, 0);
        // An op offered mid-access must be ignored.
        drive_op(1'b1, 1'b0, 1'b0, 8'h99, 8'h00);
        step();
        chk("ld_req_c2",   mem_req,  1);
        chk("ld_rdy_c2",   in_ready, 0);
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        chk("ld_req_c3",   mem_req,  1);
        chk("ld_addr_c3",  mem_addr, 8'h10);
        chk("ld_rdy_c3",   in_ready, 0);
        chk("ld_noval_c3", out_valid, 0);
        mem_ack   = 1'b1;
        mem_rdata = 8'hA5;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        chk("ld_out_valid", out_valid, 1);
        chk("ld_result",    result,    8'hA5);
        chk("ld_err",       err,       0);
        chk("ld_req_drop",  mem_req,   0);
        step();
        chk("ld_idle_valid", out_valid, 0);

        // Store, ack in first ACCESS cycle, Writeback stalls 4 cycles
        out_ready = 1'b0;
        drive_op(1'b1, 1'b0, 1'b1, 8'h20, 8'h77);
        step();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("st_req",   mem_req,   1);
        chk("st_we",    mem_we,    1);
        chk("st_addr",  mem_addr,  8'h20);
        chk("st_wdata", mem_wdata, 8'h77);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("st_hold_valid", out_valid, 1);
            chk("st_hold_result", result,   8'h77);
            chk("st_hold_err",   err,       0);
            chk("st_hold_rdy",   in_ready,  0);
            // Stray ack in DONE must not disturb the held result.
            mem_ack   = (i == 1);
            mem_rdata = 8'hEE;
            step();
            mem_ack   = 1'b0;
        end
        out_ready = 1'b1;
        #1;
        chk("st_rdy_release", in_ready, 1);
        step();
        chk("st_idle_valid", out_valid, 0);

        // Back-to-back non-memory ops, no bubble
        drive_op(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
        step();
        chk("b2b_valid1",  out_valid, 1);
        chk("b2b_result1", result,    8'h01);
        chk("b2b_rdy1",    in_ready,  1);
        drive_op(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
        step();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("b2b_valid2",  out_valid, 1);
        chk("b2b_result2", result,    8'h02);
        step();
        chk("b2b_idle",    out_valid, 0);

        // Illegal op: both read and write
        drive_op(1'b1, 1'b1, 1'b1, 8'h5A, 8'h11);
        step();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("ill_valid",  out_valid, 1);
        chk("ill_err",    err,       1);
        chk("ill_result", result,    8'h5A);
        chk("ill_req",    mem_req,   0);
        step();

        // Reset in the middle of a load; the late ack must be ignored
        drive_op(1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
        step();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rac_req", mem_req, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rac_req_drop", mem_req,   0);
        chk("rac_valid",    out_valid, 0);
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        step();
        mem_ack   = 1'b0;
        chk("rac_late_valid", out_valid, 0);
        chk("rac_late_rdy",   in_ready,  1);
        chk("rac_late_req",   mem_req,   0);
        step();
        chk("rac_late_valid2", out_valid, 0);

        // Reset in DONE discards the pending result
        out_ready = 1'b0;
        drive_op(1'b1, 1'b0, 1'b0, 8'hC7, 8'h00);
        step();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rdn_valid_pre", out_valid, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rdn_valid",  out_valid, 0);
        chk("rdn_result", result,    0);
        out_ready = 1'b1;
        step();

`ifdef MEMACC_TIMEOUT_EN
        // No ack: abort after TIMEOUT ACCESS cycles
        drive_op(1'b1, 1'b1, 1'b0, 8'h30, 8'h00);
        step();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 1; i <= TIMEOUT; i++) begin
            chk("to_req_high", mem_req, 1);
            step();
        end
        chk("to_req_drop", mem_req,   0);
        chk("to_valid",    out_valid, 1);
        chk("to_err",      err,       1);
        chk("to_result",   result,    0);
        step();

        // Ack in the expiry cycle completes normally
        drive_op(1'b1, 1'b1, 1'b0, 8'h31, 8'h00);
        step();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 1; i <= TIMEOUT; i++) begin
            chk("toa_req_high", mem_req, 1);
            if (i == TIMEOUT) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hC3;
            end
            step();
            mem_ack = 1'b0;
        end
        chk("toa_valid",  out_valid, 1);
        chk("toa_err",    err,       0);
        chk("toa_result", result,    8'hC3);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
